// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline.
// Holds the decoded control bundle (ctrl_t), the ALU operation encoding and the
// bubble control constant CTRL_NOP. Imported by the decoder, the ID/EX stage and
// the forwarding unit so all of them agree on the control layout.
package core_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9,
    AluLui  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  // All side-effect enables off; ADD keeps the ALU in a harmless mode.
  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    jump:       1'b0,
    alu_op:     AluAdd
  };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator.
// Flags when the instruction in ID reads a register that the load currently in
// EX will write, so the pipeline must insert one bubble.
// Ports:
//   id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i : ID instruction
//   ex_valid_i, ex_mem_read_i, ex_rd_i                         : ID/EX contents
//   load_use_o                                                 : hazard present
module load_use_detect (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    // x0 is never written, so a load to x0 cannot create a dependency.
    load_use_o = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                 (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded operands and control from ID each cycle and presents them to
// EX and the forwarding unit. Update priority: rst > ex_flush > mem_stall >
// load_use > capture. Flush and load-use insert a bubble, mem_stall holds.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   id_*_i                    : decoded ID instruction
//   ex_flush_i                : taken branch/jump in EX, kill ID instruction
//   mem_stall_i               : downstream stall, freeze ID/EX
//   id_ex_*_o                 : registered ID/EX contents
//   stall_if_id_o             : combinational hold request for PC and IF/ID
//   load_use_cnt_o, flush_cnt_o : saturating hazard event counters
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  ctrl_t            id_ctrl_i,
  input  logic             ex_flush_i,
  input  logic             mem_stall_i,
  output logic             id_ex_valid_o,
  output logic [XLEN-1:0]  id_ex_pc_o,
  output logic [4:0]       id_ex_rs1_o,
  output logic [4:0]       id_ex_rs2_o,
  output logic [4:0]       id_ex_rd_o,
  output logic [XLEN-1:0]  id_ex_rs1_data_o,
  output logic [XLEN-1:0]  id_ex_rs2_data_o,
  output logic [XLEN-1:0]  id_ex_imm_o,
  output ctrl_t            id_ex_ctrl_o,
  output logic             stall_if_id_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic             valid_q,    valid_d;
  logic [XLEN-1:0]  pc_q,       pc_d;
  logic [4:0]       rs1_q,      rs1_d;
  logic [4:0]       rs2_q,      rs2_d;
  logic [4:0]       rd_q,       rd_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q,      imm_d;
  ctrl_t            ctrl_q,     ctrl_d;
  logic [CNT_W-1:0] lu_cnt_q,   lu_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q,   fl_cnt_d;

  logic load_use;

  load_use_detect u_load_use_detect (
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_use_rs1_i  (id_use_rs1_i),
    .id_use_rs2_i  (id_use_rs2_i),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .load_use_o    (load_use)
  );

  // A flush discards the ID instruction, so holding IF/ID for a hazard is moot.
  assign stall_if_id_o = (load_use && !ex_flush_i) || mem_stall_i;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    ctrl_d     = ctrl_q;
    lu_cnt_d   = lu_cnt_q;
    fl_cnt_d   = fl_cnt_q;

    if (ex_flush_i || (!mem_stall_i && load_use)) begin
      // Bubble: zero indices keep the forwarding unit from matching.
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      ctrl_d     = CTRL_NOP;
      if (ex_flush_i) begin
        if (fl_cnt_q != {CNT_W{1'b1}}) fl_cnt_d = fl_cnt_q + CNT_W'(1);
      end else begin
        if (lu_cnt_q != {CNT_W{1'b1}}) lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end
    end else if (!mem_stall_i) begin
      valid_d    = id_valid_i;
      pc_d       = id_pc_i;
      rs1_d      = id_rs1_i;
      rs2_d      = id_rs2_i;
      rd_d       = id_rd_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      ctrl_d     = id_valid_i ? id_ctrl_i : CTRL_NOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      ctrl_q     <= CTRL_NOP;
      lu_cnt_q   <= '0;
      fl_cnt_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
      lu_cnt_q   <= lu_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
    end
  end

  assign id_ex_valid_o    = valid_q;
  assign id_ex_pc_o       = pc_q;
  assign id_ex_rs1_o      = rs1_q;
  assign id_ex_rs2_o      = rs2_q;
  assign id_ex_rd_o       = rd_q;
  assign id_ex_rs1_data_o = rs1_data_q;
  assign id_ex_rs2_data_o = rs2_data_q;
  assign id_ex_imm_o      = imm_q;
  assign id_ex_ctrl_o     = ctrl_q;
  assign load_use_cnt_o   = lu_cnt_q;
  assign flush_cnt_o      = fl_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. Captures decoded operands and control from ID each cycle and presents them to EX and to the data-forwarding unit (the `id_ex_rs1`/`id_ex_rs2`/`id_ex_rd` fields come from here). Inserts bubbles on load-use hazards and branch flushes, holds on downstream stall, and keeps 32-bit hazard event counters for performance debug.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of event counters

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands, immediate
- id_ctrl  in  ctrl_t  decoded control (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump, alu_op[3:0])
- ex_flush  in  1  branch/jump taken in EX; kill ID instruction
- mem_stall  in  1  downstream stall; freeze ID/EX
- id_ex_valid, id_ex_pc, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_ctrl  out  registered copies
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational)
- load_use_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- load_use = id_valid & id_ex_valid & id_ex_ctrl.MemRead & id_ex_rd≠0 & ((id_use_rs1 & id_rs1==id_ex_rd) | (id_use_rs2 & id_rs2==id_ex_rd)).
- stall_if_id = (load_use & ~ex_flush) | mem_stall.
- Per-cycle update priority (highest first): rst > ex_flush > mem_stall > load_use > capture.
  - ex_flush: load bubble (overrides mem_stall; EX instruction is the branch, already resolved).
  - mem_stall: all registers hold.
  - load_use: load bubble; ID instruction stays in IF/ID via stall_if_id, re-evaluated next cycle.
  - capture: all id_* copied; id_ex_valid = id_valid.
- Bubble: valid=0, ctrl=CTRL_NOP (all enables 0, alu_op=ADD), rs1=rs2=rd=0, pc/data/imm=0. Zero indices guarantee the forwarding unit sees no match.
- If id_valid=0 on capture, ctrl is forced to CTRL_NOP regardless of id_ctrl.
- Counters: load_use_cnt +1 each cycle the load_use bubble branch is taken; flush_cnt +1 each ex_flush cycle. Both saturate at all-ones, no wrap.

## Timing
- All id_ex_* outputs: registered, 1-cycle latency from ID inputs.
- stall_if_id: combinational, same cycle as inputs; no registered path.
- Reset (async assert, sync-to-clk deassert handled upstream): all outputs bubble values, counters 0, stall_if_id follows inputs (0 when id_ex_valid=0 and mem_stall=0).
- Load-use costs exactly one bubble: after bubble, id_ex holds NOP so load_use drops; forwarding from MEM/WB covers the dependency.
- ex_flush and load_use same cycle: flush wins, stall_if_id=0 (unless mem_stall), load_use_cnt not incremented.
- mem_stall and load_use same cycle: hold, no bubble, load_use_cnt not incremented; hazard re-evaluated after stall releases.
- Reset mid-stall: immediate bubble state, counters cleared.

## Structure
- Shared package core_pkg: ctrl_t packed struct, CTRL_NOP constant, alu_op enum. Forwarding unit and decoder import the same package.
- One sub-module natural: load_use_detect (purely combinational comparator, reused by any future hazard logic). Registers and counters stay in id_ex_stage.

## Test plan
- Plain capture: id_valid=1, rs1=3, rs2=4, rd=5, RegWrite=1 → next cycle id_ex_rs1=3, id_ex_rs2=4, id_ex_rd=5, id_ex_valid=1, stall_if_id=0.
- Load-use: id_ex holds lw x5; ID add x6,x5,x1 with id_use_rs1=1 → stall_if_id=1 this cycle, next cycle id_ex bubble (valid=0, rd=0), load_use_cnt=1; following cycle add captured.
- No false hazard: id_ex lw x0, or ID rs2=5 with id_use_rs2=0 (I-type) → no stall, capture.
- Flush priority: ex_flush=1 with load_use and mem_stall both true → bubble, flush_cnt+1, load_use_cnt unchanged, stall_if_id=1 only from mem_stall.
- mem_stall hold: 3 cycles mem_stall=1 with changing id_* → id_ex_* constant; release → capture of current ID.
- Reset mid-operation: assert rst asynchronously between edges with valid data → outputs bubble and counters 0 immediately; counter saturation checked by forcing load_use_cnt near all-ones (CNT_W=4 build) → stays 15.
